// File: rtl/timer_ctrl_pkg.sv
// timer_ctrl_pkg: register map, bit positions and FSM encoding shared by the timer control slice
package timer_ctrl_pkg;
  localparam logic [1:0] ADDR_MAX    = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_LIMIT  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;
  localparam int CTRL_IRQ_EN = 1;
  localparam int STAT_PEND   = 0;
  localparam int STAT_RUN    = 1;
  localparam int STAT_DONE   = 16;
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;
endpackage

// File: rtl/timer_regs.sv
// timer_regs: software-visible timer registers, pend write-1-to-clear and combinational read mux
module timer_regs
  import timer_ctrl_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int LIM_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_wr,
  input  logic [1:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  output logic [31:0]      cfg_rdata,
  input  logic             pend_set,
  input  logic             running,
  input  logic [LIM_W-1:0] done_cnt,
  output logic [CNT_W-1:0] max_val,
  output logic             irq_en,
  output logic [LIM_W-1:0] limit,
  output logic             pend
);
  logic w1c;
  logic unused_wdata;
  assign unused_wdata = ^cfg_wdata;
  assign w1c = cfg_wr && cfg_addr == ADDR_STATUS && cfg_wdata[STAT_PEND];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_val <= '0;
      irq_en  <= 1'b0;
      limit   <= '0;
      pend    <= 1'b0;
    end else begin
      if (cfg_wr && cfg_addr == ADDR_MAX) max_val <= cfg_wdata[CNT_W-1:0];
      if (cfg_wr && cfg_addr == ADDR_CTRL) irq_en <= cfg_wdata[CTRL_IRQ_EN];
      if (cfg_wr && cfg_addr == ADDR_LIMIT) limit <= cfg_wdata[LIM_W-1:0];
      // a new period end outranks a simultaneous clear so no event is lost
      pend <= pend_set || (pend && !w1c);
    end
  end
  always_comb begin
    cfg_rdata = cfg_addr == ADDR_MAX   ? 32'(max_val) :
                cfg_addr == ADDR_CTRL  ? 32'(irq_en) << CTRL_IRQ_EN :
                cfg_addr == ADDR_LIMIT ? 32'(limit) :
                (32'(done_cnt) << STAT_DONE) | (32'(running) << STAT_RUN) | (32'(pend) << STAT_PEND);
  end
endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: start/stop/period-limit control for a repeating up-counter, with shadowed period
// maximum, completed-period count and level interrupt
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int LIM_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trig,
  input  logic             stop,
  input  logic             cfg_wr,
  input  logic [1:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  output logic [31:0]      cfg_rdata,
  input  logic [CNT_W-1:0] cnt,
  output logic             en,
  output logic [CNT_W-1:0] cfg_max,
  output logic             irq
);
  state_t state, state_nx;
  logic [LIM_W-1:0] done_cnt, done_nx, limit;
  logic [CNT_W-1:0] max_val, max_nx;
  logic irq_en, pend, pe, last;
  assign en = state == ST_RUN;
  assign pe = en && cnt >= cfg_max;
  assign last = pe && limit != '0 && done_cnt == limit - LIM_W'(1);
  assign irq = irq_en & pend;
  always_comb begin
    state_nx = state;
    done_nx  = done_cnt;
    max_nx   = cfg_max;
    if (state == ST_IDLE) begin
      max_nx = max_val;
      if (trig && !stop) begin
        state_nx = ST_RUN;
        done_nx  = '0;
      end
    end else begin
      // the shadow only moves at a period boundary so a running period keeps its length
      if (pe) begin
        max_nx  = max_val;
        done_nx = done_cnt == '1 ? done_cnt : done_cnt + LIM_W'(1);
      end
      if (stop || last) state_nx = ST_IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      done_cnt <= '0;
      cfg_max  <= '0;
    end else begin
      state    <= state_nx;
      done_cnt <= done_nx;
      cfg_max  <= max_nx;
    end
  end
  timer_regs #(.CNT_W(CNT_W), .LIM_W(LIM_W)) u_regs (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_wr   (cfg_wr),
    .cfg_addr (cfg_addr),
    .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata),
    .pend_set (pe),
    .running  (en),
    .done_cnt (done_cnt),
    .max_val  (max_val),
    .irq_en   (irq_en),
    .limit    (limit),
    .pend     (pend)
  );
endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: timer_ctrl with an attached counter, checked every cycle against a behavioural model
module tb_timer_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, trig = 1'b0, stop = 1'b0, cfg_wr = 1'b0;
  logic [1:0] cfg_addr = 2'd0;
  logic [31:0] cfg_wdata = '0, cfg_rdata, cnt, cfg_max;
  logic en, irq;
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  timer_ctrl dut (
    .clk(clk), .rst_n(rst_n), .trig(trig), .stop(stop), .cfg_wr(cfg_wr),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .cnt(cnt), .en(en), .cfg_max(cfg_max), .irq(irq)
  );

  // downstream repeating up-counter
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (!en || cnt >= cfg_max) ? 32'd0 : cnt + 32'd1;

  // behavioural model
  logic m_run, m_irq_en, m_pend, m_pe;
  logic [31:0] m_max, m_shadow;
  logic [15:0] m_limit, m_done;
  assign m_pe = m_run && (cnt >= m_shadow);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 1'b0; m_irq_en <= 1'b0; m_pend <= 1'b0;
      m_max <= '0; m_shadow <= '0; m_limit <= '0; m_done <= '0;
    end else begin
      m_shadow <= (!m_run || m_pe) ? m_max : m_shadow;
      if (!m_run) begin
        if (trig && !stop) begin m_run <= 1'b1; m_done <= '0; end
      end else begin
        if (m_pe) m_done <= (m_done == 16'hFFFF) ? m_done : m_done + 16'd1;
        if (stop || (m_pe && m_limit != 0 && int'(m_done) + 1 == int'(m_limit))) m_run <= 1'b0;
      end
      m_pend <= m_pe || (m_pend && !(cfg_wr && cfg_addr == 2'd3 && cfg_wdata[0]));
      if (cfg_wr && cfg_addr == 2'd0) m_max <= cfg_wdata;
      if (cfg_wr && cfg_addr == 2'd1) m_irq_en <= cfg_wdata[1];
      if (cfg_wr && cfg_addr == 2'd2) m_limit <= cfg_wdata[15:0];
    end
  end

  function automatic logic [31:0] m_read(input logic [1:0] a);
    return a == 2'd0 ? m_max :
           a == 2'd1 ? {30'd0, m_irq_en, 1'b0} :
           a == 2'd2 ? {16'd0, m_limit} :
                       {m_done, 14'd0, m_run, m_pend};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("en", 32'(en), 32'(m_run));
    chk("cfg_max", cfg_max, m_shadow);
    chk("irq", 32'(irq), 32'(m_irq_en & m_pend));
    chk("cfg_rdata", cfg_rdata, m_read(cfg_addr));
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_wr = 1'b0;
  endtask

  task automatic wait_cnt(input logic [31:0] v);
    int k = 0;
    while (cnt !== v && k < 200) begin step(); k++; end
    if (cnt !== v) chk("wait_cnt_timeout", cnt, v);
  endtask

  initial begin
    int n_en, irq_idx, pe_idx;
    logic [31:0] s[14];
    logic [15:0] d0;
    // reset state
    idle(3);
    chk("rst_en", 32'(en), 0);
    chk("rst_cfg_max", cfg_max, 0);
    chk("rst_irq", 32'(irq), 0);
    for (int a = 0; a < 4; a++) begin cfg_addr = 2'(a); #1; chk("rst_rdata", cfg_rdata, 0); end
    step(); rst_n = 1'b1; step();

    // limited run: 2 periods of 5
    wr(2'd0, 32'd4); wr(2'd2, 32'd2); wr(2'd1, 32'd2);
    trig = 1'b1; step(); trig = 1'b0;
    n_en = 0; irq_idx = -1; pe_idx = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n_en += int'(en);
      if (pe_idx < 0 && en && cnt == 32'd4) pe_idx = i;
      if (irq_idx < 0 && irq) irq_idx = i;
    end
    chk("t1_en_cycles", 32'(n_en), 32'd10);
    chk("t1_pe_idx", 32'(pe_idx), 32'd4);
    chk("t1_irq_idx", 32'(irq_idx), 32'd5);
    step(); cfg_addr = 2'd3; #1;
    chk("t1_done_cnt", 32'(cfg_rdata[31:16]), 32'd2);
    chk("t1_running", 32'(cfg_rdata[1]), 0);
    chk("t1_pend", 32'(cfg_rdata[0]), 32'd1);

    // MAX write mid-period takes effect at the next period
    wr(2'd3, 32'd1); wr(2'd2, 32'd0); wr(2'd0, 32'd3);
    trig = 1'b1; step(); trig = 1'b0;
    idle(9);
    chk("t2_cnt_mid", cnt, 32'd1);
    wr(2'd0, 32'd7);
    for (int i = 0; i < 14; i++) begin @(negedge clk); s[i] = cnt; end
    chk("t2_s0", s[0], 32'd2);
    chk("t2_s1", s[1], 32'd3);
    chk("t2_wrap_old", s[2], 32'd0);
    chk("t2_peak_new", s[9], 32'd7);
    chk("t2_wrap_new", s[10], 32'd0);
    chk("t2_en", 32'(en), 32'd1);

    // stop on the same cycle as pe
    step();
    wait_cnt(32'd2);
    wr(2'd3, 32'd1); cfg_addr = 2'd3; #1;
    chk("t3_pend_clr", 32'(cfg_rdata[0]), 0);
    idle(4);
    chk("t3_cnt7", cnt, 32'd7);
    d0 = cfg_rdata[31:16];
    stop = 1'b1; step(); stop = 1'b0;
    chk("t3_en", 32'(en), 0);
    chk("t3_done", 32'(cfg_rdata[31:16]), 32'(d0) + 32'd1);
    chk("t3_pend", 32'(cfg_rdata[0]), 32'd1);

    // W1C on a pe cycle loses to the set; a lone W1C clears
    wr(2'd0, 32'd2);
    trig = 1'b1; step(); trig = 1'b0;
    wait_cnt(32'd2);
    wr(2'd3, 32'd1);
    chk("t4_pend_kept", 32'(cfg_rdata[0]), 32'd1);
    wr(2'd3, 32'd1);
    chk("t4_pend_clr", 32'(cfg_rdata[0]), 0);
    chk("t4_irq_clr", 32'(irq), 0);
    d0 = cfg_rdata[31:16];
    trig = 1'b1; step(); trig = 1'b0;
    chk("t4_no_restart_en", 32'(en), 32'd1);
    chk("t4_no_restart_done", 32'(cfg_rdata[31:16]), 32'(d0));
    chk("t4_cnt_unbroken", cnt, 32'd2);
    stop = 1'b1; step(); stop = 1'b0;
    idle(2);
    trig = 1'b1; stop = 1'b1; step(); trig = 1'b0; stop = 1'b0;
    chk("t4_trig_stop_en", 32'(en), 0);
    step();
    chk("t4_trig_stop_en2", 32'(en), 0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      trig = $urandom_range(0, 7) == 0;
      stop = $urandom_range(0, 31) == 0;
      cfg_wr = $urandom_range(0, 5) == 0;
      cfg_addr = 2'($urandom_range(0, 3));
      cfg_wdata = cfg_addr == 2'd0 ? (($urandom_range(0, 15) == 0) ? $urandom : $urandom_range(0, 9)) :
                  cfg_addr == 2'd2 ? $urandom_range(0, 4) : $urandom;
      step();
    end
    trig = 1'b0; stop = 1'b0; cfg_wr = 1'b0;

    // asynchronous reset mid-period
    wr(2'd2, 32'd0); wr(2'd1, 32'd2); wr(2'd0, 32'd5);
    trig = 1'b1; step(); trig = 1'b0;
    idle(3);
    rst_n = 1'b0; #1;
    chk("ar_en", 32'(en), 0);
    chk("ar_cfg_max", cfg_max, 0);
    chk("ar_irq", 32'(irq), 0);
    @(negedge clk); #1;
    for (int a = 0; a < 4; a++) begin cfg_addr = 2'(a); #1; chk("ar_rdata", cfg_rdata, 0); end
    step(); rst_n = 1'b1; step();
    trig = 1'b1; step(); trig = 1'b0;
    chk("ar_restart_en", 32'(en), 32'd1);
    chk("ar_restart_cnt", cnt, 0);
    chk("ar_restart_max", cfg_max, 0);
    step();
    chk("ar_max0_cnt", cnt, 0);
    chk("ar_max0_en", 32'(en), 32'd1);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
